spi_flash_ctrl: RTL and testbench

//   Read-only memory-mapped controller for the EN25F80 SPI flash.
//   - Accepts word reads from devctrl (flashEnable/flashReadEnable/addr, flashDataLoad/flashBusy).
//   - Issues a READ (0x03) command per word in SPI mode 0 and stalls the CPU via busy_o.
//   - Writes are not supported: a write request is accepted and ignored.

---
 rtl/spi_flash_ctrl_pkg.sv | 21 ++
 rtl/spi_flash_ctrl_if.sv | 11 +
 rtl/spi_flash_ctrl_bit_timer.sv | 41 ++++
 rtl/spi_flash_ctrl.sv | 126 ++++++++++++
 tb/tb_spi_flash_ctrl.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_flash_ctrl_pkg.sv
// Shared definitions for the EN25F80 read-only SPI flash controller:
// command opcode, FSM state encoding and the little-endian word assembly helper.
package spi_flash_ctrl_pkg;

    localparam logic [7:0] FLASH_CMD_READ = 8'h03;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT,
        ST_HOLD,
        ST_DONE,
        ST_GAP
    } state_t;

    // Bytes arrive MSB-first in the receive shift register; the first byte belongs in [7:0].
    function automatic logic [31:0] bswap32(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

endpackage

// File: rtl/spi_flash_ctrl_if.sv
// CPU-side word-read bus between devctrl and the SPI flash controller.
interface spi_flash_ctrl_if;
    logic        devEnable_i;
    logic        readEnable_i;
    logic [31:0] addr_i;
    logic [31:0] readData_o;
    logic        busy_o;

    modport slave  (input  devEnable_i, readEnable_i, addr_i, output readData_o, busy_o);
    modport master (output devEnable_i, readEnable_i, addr_i, input  readData_o, busy_o);
endinterface

// File: rtl/spi_flash_ctrl_bit_timer.sv
// SCLK generator: CLK_DIV-cycle half periods, starting low, with strobes on the
// clk edges that raise and lower SCLK. Held cleared while not enabled.
module spi_bit_timer #(
    parameter int unsigned CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic sclk,
    output logic rise,
    output logic fall
);

    localparam int unsigned   CW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic          phase_q;
    logic          wrap;

    assign wrap = en && (cnt_q == LAST);
    assign rise = wrap && !phase_q;
    assign fall = wrap && phase_q;
    assign sclk = phase_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            phase_q <= 1'b0;
        end else if (!en) begin
            cnt_q   <= '0;
            phase_q <= 1'b0;
        end else if (wrap) begin
            cnt_q   <= '0;
            phase_q <= !phase_q;
        end else begin
            cnt_q   <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/spi_flash_ctrl.sv
// Read-only memory-mapped controller for the EN25F80: one READ (0x03) command per
// CPU word read in SPI mode 0, stalling the CPU through busy_o. Writes are ignored.
module spi_flash_ctrl
    import spi_flash_ctrl_pkg::*;
#(
    parameter int unsigned CLK_DIV   = 2,
    parameter int unsigned ADDR_BITS = 20,
    parameter int unsigned CS_GAP    = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    spi_flash_ctrl_if.slave  bus,
    output logic             spiClk_o,
    output logic             spiCs_n_o,
    output logic             spiDi_o,
    input  logic             spiDo_i
);

    localparam int unsigned GW = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;

    state_t        state_q, state_d;
    logic [63:0]   sr_q;
    logic [5:0]    bit_q;
    logic [GW-1:0] gap_q;
    logic          miso_q;
    logic [31:0]   rdata_q;
    logic [23:0]   flash_addr;
    logic          req, load, busy;
    logic          sclk_lvl, rise, fall;

    assign req = bus.devEnable_i && bus.readEnable_i;

    always_comb begin
        flash_addr = '0;
        flash_addr[ADDR_BITS-1:2] = bus.addr_i[ADDR_BITS-1:2];
    end

    spi_bit_timer #(.CLK_DIV(CLK_DIV)) u_bit_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (state_q == ST_SHIFT),
        .sclk  (sclk_lvl),
        .rise  (rise),
        .fall  (fall)
    );

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        busy    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                busy = req;
                if (req) begin
                    load    = 1'b1;
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                busy    = 1'b1;
                state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                busy = 1'b1;
                if (fall && bit_q == 6'd63) state_d = ST_HOLD;
            end
            ST_HOLD: begin
                busy    = 1'b1;
                state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = (CS_GAP > 1) ? ST_GAP : ST_IDLE;
            end
            ST_GAP: begin
                // A request waiting here launches directly once tSHSL is met.
                busy = req;
                if (gap_q == '0) begin
                    if (req) begin
                        load    = 1'b1;
                        state_d = ST_SETUP;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            sr_q    <= '0;
            bit_q   <= '0;
            gap_q   <= '0;
            miso_q  <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (load) begin
                sr_q  <= {FLASH_CMD_READ, flash_addr, 32'h0};
                bit_q <= '0;
            end else if (state_q == ST_SHIFT) begin
                // MISO sampled on the rising edge enters the vacated LSB on the falling edge.
                if (rise) miso_q <= spiDo_i;
                if (fall) begin
                    sr_q  <= {sr_q[62:0], miso_q};
                    bit_q <= bit_q + 6'd1;
                end
            end
            if (state_q == ST_HOLD) rdata_q <= bswap32(sr_q[31:0]);
            if (state_q == ST_DONE) begin
                gap_q <= GW'(CS_GAP - 2);
            end else if (state_q == ST_GAP && gap_q != '0) begin
                gap_q <= gap_q - 1'b1;
            end
        end
    end

    assign spiCs_n_o      = !(state_q == ST_SETUP || state_q == ST_SHIFT || state_q == ST_HOLD);
    assign spiClk_o       = (state_q == ST_SHIFT) && sclk_lvl;
    assign spiDi_o        = (state_q == ST_SETUP || state_q == ST_SHIFT) && sr_q[63];
    assign bus.readData_o = rdata_q;
    assign bus.busy_o     = rst_n && busy;

endmodule

// File: tb/tb_spi_flash_ctrl.sv
// Bench for spi_flash_ctrl: two instances (CLK_DIV=2 and CLK_DIV=1) each wired to a
// behavioural EN25F80 with mem[a] = a[7:0] ^ 8'hA5 and a mode-0 protocol monitor.
module tb_spi_flash_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic sclk [2];
    logic csn  [2];
    logic mosi [2];
    logic miso [2];

    spi_flash_ctrl_if bus_a ();
    spi_flash_ctrl_if bus_b ();

    spi_flash_ctrl #(.CLK_DIV(2), .ADDR_BITS(20), .CS_GAP(3)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(bus_a),
        .spiClk_o(sclk[0]), .spiCs_n_o(csn[0]), .spiDi_o(mosi[0]), .spiDo_i(miso[0])
    );

    spi_flash_ctrl #(.CLK_DIV(1), .ADDR_BITS(20), .CS_GAP(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(bus_b),
        .spiClk_o(sclk[1]), .spiCs_n_o(csn[1]), .spiDi_o(mosi[1]), .spiDo_i(miso[1])
    );

    for (genvar g = 0; g < 2; g++) begin : g_flash
        int unsigned cnt = 0;
        logic [31:0] hdr = '0;
        logic [31:0] last_hdr = '0;
        logic        miso_r = 1'b0;
        logic        sclk_prev = 1'b0;
        int unsigned viol = 0, edges = 0, hi_cycles = 0, gap_run = 0, last_gap = 0;
        logic        s_sclk = 1'b0, s_cs = 1'b1, s_mosi = 1'b0;

        assign miso[g] = miso_r;

        // Flash model: latch command/address on SCLK rise, drive data on SCLK fall.
        always @(sclk[g] or csn[g]) begin
            int unsigned j;
            logic [19:0] a;
            logic [7:0]  b;
            if (csn[g] !== 1'b0) begin
                cnt    = 0;
                miso_r = 1'b0;
            end else if (sclk[g] && !sclk_prev) begin
                if (cnt < 32) hdr = {hdr[30:0], mosi[g]};
                cnt++;
                if (cnt == 32) last_hdr = hdr;
            end else if (!sclk[g] && sclk_prev && cnt >= 32) begin
                j      = cnt - 32;
                a      = hdr[19:0] + 20'(j / 8);
                b      = a[7:0] ^ 8'hA5;
                miso_r = b[7 - (j % 8)];
            end
            sclk_prev = sclk[g];
        end

        // Per-cycle protocol monitor, sampled away from the clock edge.
        always @(posedge clk) begin
            #2;
            if (sclk[g] !== s_sclk) begin
                edges++;
                if (csn[g] !== 1'b0 || s_cs !== 1'b0) viol++;
            end
            if (csn[g] === 1'b0 && s_cs === 1'b0 && sclk[g] === 1'b1 && mosi[g] !== s_mosi) viol++;
            if (csn[g] === 1'b0 && sclk[g] === 1'b1) hi_cycles++;
            if (csn[g] === 1'b0 && s_cs === 1'b1) begin
                last_gap  = gap_run;
                gap_run   = 0;
                hi_cycles = 0;
            end
            if (csn[g] === 1'b1) gap_run++;
            s_sclk = sclk[g];
            s_cs   = csn[g];
            s_mosi = mosi[g];
        end
    end

    int unsigned checks = 0;
    int unsigned failures = 0;
    logic [31:0] exp_q[$];

    typedef struct {
        string       name;
        logic [31:0] addr;
        logic        rd;
        logic [31:0] data;
        int unsigned lat;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input int sel, input logic en, input logic rd, input logic [31:0] addr);
        if (sel == 0) begin
            bus_a.devEnable_i = en; bus_a.readEnable_i = rd; bus_a.addr_i = addr;
        end else begin
            bus_b.devEnable_i = en; bus_b.readEnable_i = rd; bus_b.addr_i = addr;
        end
    endtask

    function automatic logic busy_of(input int sel);
        return (sel == 0) ? bus_a.busy_o : bus_b.busy_o;
    endfunction

    function automatic logic [31:0] rdata_of(input int sel);
        return (sel == 0) ? bus_a.readData_o : bus_b.readData_o;
    endfunction

    function automatic logic [31:0] hdr_of(input int sel);
        return (sel == 0) ? g_flash[0].last_hdr : g_flash[1].last_hdr;
    endfunction

    function automatic int unsigned hi_of(input int sel);
        return (sel == 0) ? g_flash[0].hi_cycles : g_flash[1].hi_cycles;
    endfunction

    task automatic run_read(input int sel, input logic [31:0] addr, input logic [31:0] exp_data,
                            input int unsigned exp_lat, input logic keep, input string name);
        int unsigned n;
        exp_q.push_back(exp_data);
        @(negedge clk);
        drive(sel, 1'b1, 1'b1, addr);
        #1;
        n = 0;
        while (busy_of(sel) && n < 1000) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= 1000) check({name, "_timeout"}, n, 0);
        if (exp_lat != 0) check({name, "_latency"}, n, exp_lat);
        check({name, "_data"}, rdata_of(sel), exp_q.pop_front());
        check({name, "_mosi_hdr"}, hdr_of(sel), {8'h03, 4'h0, addr[19:2], 2'b00});
        check({name, "_sclk_high"}, hi_of(sel), (sel == 0) ? 128 : 64);
        if (!keep) drive(sel, 1'b0, 1'b1, addr);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish expected finish before 1ms");
        $fatal(1);
    end

    initial begin
        vec_t vecs[7];
        int unsigned e0;
        vecs[0] = '{name: "rd_0x10",      addr: 32'h0000_0010, rd: 1'b1, data: 32'hB6B7B4B5, lat: 259};
        vecs[1] = '{name: "wr_ignored",   addr: 32'h0000_0040, rd: 1'b0, data: 32'hB6B7B4B5, lat: 0};
        vecs[2] = '{name: "rd_0x0",       addr: 32'h0000_0000, rd: 1'b1, data: 32'hA6A7A4A5, lat: 259};
        vecs[3] = '{name: "rd_unaligned", addr: 32'h0000_0013, rd: 1'b1, data: 32'hB6B7B4B5, lat: 259};
        vecs[4] = '{name: "rd_wrap",      addr: 32'hFFF0_0ABC, rd: 1'b1, data: 32'h1A1B1819, lat: 259};
        vecs[5] = '{name: "rd_top",       addr: 32'h000F_FFFC, rd: 1'b1, data: 32'h5A5B5859, lat: 259};
        vecs[6] = '{name: "wr_after_top", addr: 32'h0000_0000, rd: 1'b0, data: 32'h5A5B5859, lat: 0};

        drive(0, 1'b1, 1'b1, 32'h0);
        drive(1, 1'b0, 1'b1, 32'h0);
        #12;
        check("rst_busy_a", bus_a.busy_o, 0);
        check("rst_cs_a",   csn[0], 1);
        check("rst_sclk_a", sclk[0], 0);
        check("rst_mosi_a", mosi[0], 0);
        check("rst_data_a", bus_a.readData_o, 0);
        check("rst_cs_b",   csn[1], 1);
        check("rst_data_b", bus_b.readData_o, 0);
        drive(0, 1'b0, 1'b1, 32'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            if (vecs[i].rd) begin
                run_read(0, vecs[i].addr, vecs[i].data, vecs[i].lat, 1'b0, vecs[i].name);
            end else begin
                exp_q.push_back(vecs[i].data);
                @(negedge clk);
                drive(0, 1'b1, 1'b0, vecs[i].addr);
                for (int c = 0; c < 4; c++) begin
                    #1;
                    check({vecs[i].name, "_busy"}, bus_a.busy_o, 0);
                    check({vecs[i].name, "_cs"}, csn[0], 1);
                    @(negedge clk);
                end
                check({vecs[i].name, "_data"}, bus_a.readData_o, exp_q.pop_front());
                drive(0, 1'b0, 1'b0, vecs[i].addr);
            end
            repeat (6) @(negedge clk);
        end

        // Back-to-back: enable stays high, second address presented while CS is in its gap.
        run_read(0, 32'h0000_0000, 32'hA6A7A4A5, 259, 1'b1, "b2b_first");
        run_read(0, 32'h0000_0004, 32'hA2A3A0A1, 0, 1'b0, "b2b_second");
        check("b2b_cs_gap_ge3", (g_flash[0].last_gap >= 3) ? 1 : 0, 1);
        repeat (6) @(negedge clk);

        // Enable dropped and address changed mid-transfer: word still fetched from the original address.
        exp_q.push_back(32'h26272425);
        @(negedge clk);
        drive(0, 1'b1, 1'b1, 32'h0000_0080);
        repeat (20) @(negedge clk);
        drive(0, 1'b0, 1'b1, 32'h0000_0044);
        repeat (300) @(negedge clk);
        #1;
        check("drop_en_data", bus_a.readData_o, exp_q.pop_front());
        check("drop_en_cs", csn[0], 1);
        check("drop_en_hdr", g_flash[0].last_hdr, 32'h0300_0080);

        // Reset during bit 40 (low half of SCLK).
        @(negedge clk);
        drive(0, 1'b1, 1'b1, 32'h0000_0020);
        repeat (162) @(negedge clk);
        check("abort_at_bit40", g_flash[0].cnt, 40);
        e0 = g_flash[0].edges;
        rst_n = 1'b0;
        drive(0, 1'b0, 1'b1, 32'h0000_0020);
        #1;
        check("abort_cs_high", csn[0], 1);
        check("abort_sclk_low", sclk[0], 0);
        check("abort_busy", bus_a.busy_o, 0);
        check("abort_data_cleared", bus_a.readData_o, 0);
        repeat (3) @(negedge clk);
        check("abort_no_sclk_edge", g_flash[0].edges, e0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        run_read(0, 32'h0000_0020, 32'h86878485, 259, 1'b0, "post_reset");
        repeat (6) @(negedge clk);

        run_read(1, 32'h000F_FFFC, 32'h5A5B5859, 131, 1'b0, "div1_top");
        repeat (6) @(negedge clk);
        run_read(1, 32'h0000_0010, 32'hB6B7B4B5, 131, 1'b0, "div1_0x10");
        repeat (6) @(negedge clk);

        check("mode0_viol_a", g_flash[0].viol, 0);
        check("mode0_viol_b", g_flash[1].viol, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
